// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command counter: command bytes, the error
// acknowledge byte, controller states and the command decoder.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_RUN_UC  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_RUN_LC  = 8'h72;  // 'r'
  localparam logic [7:0] CMD_STOP_UC = 8'h53;  // 'S'
  localparam logic [7:0] CMD_STOP_LC = 8'h73;  // 's'
  localparam logic [7:0] CMD_CLR_UC  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_CLR_LC  = 8'h63;  // 'c'
  localparam logic [7:0] CMD_UP_UC   = 8'h55;  // 'U'
  localparam logic [7:0] CMD_UP_LC   = 8'h75;  // 'u'
  localparam logic [7:0] CMD_DOWN_UC = 8'h44;  // 'D'
  localparam logic [7:0] CMD_DOWN_LC = 8'h64;  // 'd'
  localparam logic [7:0] ACK_ERR     = 8'h3F;  // '?'

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    ACK
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_RUN,
    OP_STOP,
    OP_CLR,
    OP_UP,
    OP_DOWN
  } op_e;

  function automatic op_e decode_cmd(input logic [7:0] b);
    case (b)
      CMD_RUN_UC,  CMD_RUN_LC:  return OP_RUN;
      CMD_STOP_UC, CMD_STOP_LC: return OP_STOP;
      CMD_CLR_UC,  CMD_CLR_LC:  return OP_CLR;
      CMD_UP_UC,   CMD_UP_LC:   return OP_UP;
      CMD_DOWN_UC, CMD_DOWN_LC: return OP_DOWN;
      default:                  return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO for received command bytes. A push while full only
// succeeds when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which
  // entries are valid, so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_cmd_counter.sv
// BCD up/down counter driven by UART command bytes and buttons; each command
// is popped from a FIFO, executed, and acknowledged back over the UART.
module uart_cmd_counter
  import uart_cmd_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TICK_DIV   = 10_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  input  logic                i_btn_run,
  input  logic                i_btn_clr,
  input  logic                i_tx_busy,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_start,
  output logic [4*DIGITS-1:0] o_bcd,
  output logic                o_run,
  output logic                o_dir,
  output logic                o_fifo_ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d, ack_q, ack_d;
  logic          run_q, run_d, dir_q, dir_d, ovf_q, ovf_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] bcd_q, bcd_d, bcd_step;
  logic [7:0]    fifo_data;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic          exec, step, clr, drop;
  op_e           op;

  cmd_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .push_i (i_rx_valid),
    .data_i (i_rx_data),
    .pop_i  (fifo_pop),
    .data_o (fifo_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    ack_d      = ack_q;
    fifo_pop   = 1'b0;
    exec       = 1'b0;
    o_tx_start = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        cmd_d    = fifo_data;
        state_d  = DECODE;
      end
      DECODE: begin
        exec    = 1'b1;
        ack_d   = (decode_cmd(cmd_q) == OP_NONE) ? ACK_ERR : cmd_q;
        state_d = ACK;
      end
      ACK: if (!i_tx_busy) begin
        o_tx_start = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign op   = exec ? decode_cmd(cmd_q) : OP_NONE;
  assign step = run_q && (presc_q == PRESC_LAST);
  assign clr  = i_btn_clr || (op == OP_CLR);
  assign drop = i_rx_valid && fifo_full && !fifo_pop;

  // Ripple the +1/-1 through the digits; a digit only passes the carry on
  // when it wraps (9->0 counting up, 0->9 counting down).
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    bcd_step = bcd_q;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      digit = bcd_q[4*i +: 4];
      if (carry) begin
        if (!dir_q) begin
          if (digit == 4'd9) bcd_step[4*i +: 4] = 4'd0;
          else begin
            bcd_step[4*i +: 4] = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) bcd_step[4*i +: 4] = 4'd9;
          else begin
            bcd_step[4*i +: 4] = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    presc_d = presc_q;
    bcd_d   = bcd_q;
    if (clr) begin
      presc_d = '0;
      bcd_d   = '0;
    end else if (run_q) begin
      presc_d = step ? '0 : presc_q + 1'b1;
      if (step) bcd_d = bcd_step;
    end
    // Button toggle and 'R' toggle cancel; 'S' forces stop regardless.
    run_d = run_q ^ i_btn_run ^ (op == OP_RUN);
    if (op == OP_STOP) run_d = 1'b0;
    dir_d = dir_q;
    if (op == OP_UP)   dir_d = 1'b0;
    if (op == OP_DOWN) dir_d = 1'b1;
    ovf_d = (ovf_q && (op != OP_CLR)) || drop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      ack_q   <= '0;
      run_q   <= 1'b0;
      dir_q   <= 1'b0;
      ovf_q   <= 1'b0;
      presc_q <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ack_q   <= ack_d;
      run_q   <= run_d;
      dir_q   <= dir_d;
      ovf_q   <= ovf_d;
      presc_q <= presc_d;
      bcd_q   <= bcd_d;
    end
  end

  assign o_tx_data  = ack_q;
  assign o_bcd      = bcd_q;
  assign o_run      = run_q;
  assign o_dir      = dir_q;
  assign o_fifo_ovf = ovf_q;

endmodule

// File: tb/tb_uart_cmd_counter.sv
// Self-checking bench for uart_cmd_counter: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_uart_cmd_counter;

  localparam int DIGITS     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int TICK_DIV   = 4;
  localparam int MAXV       = 10 ** DIGITS;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [7:0]          i_rx_data = 8'h00;
  logic                i_rx_valid = 1'b0;
  logic                i_btn_run = 1'b0;
  logic                i_btn_clr = 1'b0;
  logic                i_tx_busy = 1'b0;
  logic [7:0]          o_tx_data;
  logic                o_tx_start;
  logic [4*DIGITS-1:0] o_bcd;
  logic                o_run, o_dir, o_fifo_ovf;

  uart_cmd_counter #(
    .DIGITS    (DIGITS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TICK_DIV  (TICK_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_rx_data (i_rx_data),
    .i_rx_valid(i_rx_valid),
    .i_btn_run (i_btn_run),
    .i_btn_clr (i_btn_clr),
    .i_tx_busy (i_tx_busy),
    .o_tx_data (o_tx_data),
    .o_tx_start(o_tx_start),
    .o_bcd     (o_bcd),
    .o_run     (o_run),
    .o_dir     (o_dir),
    .o_fifo_ovf(o_fifo_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: count as a plain integer, FIFO as a queue, and the
  // command in flight tracked by how far it has progressed (0 none,
  // 1 popped awaiting execution, 2 executed awaiting transmit).
  logic [7:0] m_q[$];
  int         m_val, m_presc, m_phase;
  logic       m_run, m_dir, m_ovf;
  logic [7:0] m_cmd, m_ack;
  bit         cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 none, 1 run toggle, 2 stop, 3 clear, 4 up, 5 down
  function automatic int cmd_kind(input logic [7:0] b);
    case (b)
      "R", "r": return 1;
      "S", "s": return 2;
      "C", "c": return 3;
      "U", "u": return 4;
      "D", "d": return 5;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = 0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_val = 0; m_presc = 0; m_phase = 0;
    m_run = 1'b0; m_dir = 1'b0; m_ovf = 1'b0;
    m_cmd = 8'h00; m_ack = 8'h00;
  endtask

  task automatic model_step();
    int         kind;
    bit         pop, step, clear, drop;
    logic [7:0] popped = 8'h00;
    kind  = (m_phase == 1) ? cmd_kind(m_cmd) : 0;
    pop   = (m_phase == 0) && (m_q.size() > 0);
    step  = m_run && (m_presc == TICK_DIV - 1);
    clear = i_btn_clr || (kind == 3);
    if (clear) begin
      m_val = 0; m_presc = 0;
    end else if (m_run) begin
      if (step) m_val = m_dir ? (m_val + MAXV - 1) % MAXV : (m_val + 1) % MAXV;
      m_presc = (m_presc + 1) % TICK_DIV;
    end
    if (kind == 2) m_run = 1'b0;
    else           m_run = m_run ^ i_btn_run ^ (kind == 1);
    if (kind == 4) m_dir = 1'b0;
    if (kind == 5) m_dir = 1'b1;
    if (pop) popped = m_q.pop_front();
    drop = 1'b0;
    if (i_rx_valid) begin
      if (m_q.size() < FIFO_DEPTH) m_q.push_back(i_rx_data);
      else drop = 1'b1;
    end
    if (kind == 3) m_ovf = 1'b0;
    if (drop)      m_ovf = 1'b1;
    case (m_phase)
      0: if (pop) begin m_cmd = popped; m_phase = 1; end
      1: begin m_ack = (kind == 0) ? 8'h3F : m_cmd; m_phase = 2; end
      default: if (!i_tx_busy) m_phase = 0;
    endcase
  endtask

  // Advance one clock; the model sees the same inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_bcd(input logic [7:0] target, input int budget, input string name);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (o_bcd == target) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check(name, 32'(found), 32'd1);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_bcd",      32'(o_bcd),      to_bcd(m_val));
      check("cyc_run",      32'(o_run),      32'(m_run));
      check("cyc_dir",      32'(o_dir),      32'(m_dir));
      check("cyc_ovf",      32'(o_fifo_ovf), 32'(m_ovf));
      check("cyc_tx_data",  32'(o_tx_data),  32'(m_ack));
      check("cyc_tx_start", 32'(o_tx_start), 32'((m_phase == 2) && !i_tx_busy));
    end
  end

  initial begin
    int acks;
    logic [7:0] pool [10] = '{8'h52, 8'h72, 8'h53, 8'h73, 8'h43,
                              8'h63, 8'h55, 8'h75, 8'h44, 8'h64};
    logic [7:0] junk [6]  = '{"x", "y", "z", "q", "w", "k"};

    model_reset();
    cmp_en = 1'b1;
    repeat (3) tick();
    check("rst_bcd",      32'(o_bcd),      32'h0);
    check("rst_run",      32'(o_run),      32'h0);
    check("rst_tx_data",  32'(o_tx_data),  32'h0);
    check("rst_tx_start", 32'(o_tx_start), 32'h0);
    reset = 1'b1;
    tick();

    // 'r': run visible and ack pulses at t+3; first step four cycles later
    send_byte("r");
    tick();
    check("r_run_t2", 32'(o_run), 32'h0);
    tick();
    check("r_run_t3",      32'(o_run),      32'h1);
    check("r_tx_start_t3", 32'(o_tx_start), 32'h1);
    check("r_tx_data_t3",  32'(o_tx_data),  32'h72);
    repeat (3) tick();
    check("r_bcd_t6", 32'(o_bcd), 32'h00);
    tick();
    check("r_bcd_t7", 32'(o_bcd), 32'h01);

    // Up-count wrap, then direction change from 0x00
    wait_bcd(8'h98, 600, "reach_98");
    wait_bcd(8'h99, 8, "up_99");
    wait_bcd(8'h00, 8, "wrap_00");
    send_byte("d");
    wait_bcd(8'h99, 8, "down_wrap_99");
    send_byte("s");
    repeat (2) tick();
    check("s_run", 32'(o_run), 32'h0);
    repeat (6) tick();
    check("s_bcd_hold", 32'(o_bcd), 32'h99);

    // Unknown byte: error ack, no state change
    send_byte("x");
    repeat (2) tick();
    check("x_tx_data",  32'(o_tx_data),  32'h3F);
    check("x_tx_start", 32'(o_tx_start), 32'h1);
    check("x_run",      32'(o_run),      32'h0);
    check("x_dir",      32'(o_dir),      32'h1);
    check("x_bcd",      32'(o_bcd),      32'h99);
    repeat (2) tick();

    // Overflow: six back-to-back bytes while the transmitter is busy
    i_tx_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      i_rx_data  = junk[i];
      i_rx_valid = 1'b1;
      tick();
    end
    i_rx_valid = 1'b0;
    check("ovf_set", 32'(o_fifo_ovf), 32'h1);
    repeat (10) tick();
    i_tx_busy = 1'b0;
    #1;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_tx_start) acks++;
      tick();
    end
    check("ovf_ack_count", 32'(acks), 32'd5);
    send_byte("c");
    repeat (2) tick();
    check("c_ovf", 32'(o_fifo_ovf), 32'h0);
    check("c_bcd", 32'(o_bcd),      32'h00);
    check("c_dir", 32'(o_dir),      32'h1);
    repeat (2) tick();

    // Button toggle in the cycle 'R' executes cancels out
    send_byte("R");
    tick();
    i_btn_run = 1'b1;
    tick();
    i_btn_run = 1'b0;
    check("btn_R_cancel", 32'(o_run), 32'h0);
    repeat (2) tick();

    // Button clear on a step cycle wins (down-step would give 0x99)
    i_btn_run = 1'b1;
    tick();
    i_btn_run = 1'b0;
    check("btn_run_on", 32'(o_run), 32'h1);
    repeat (3) tick();
    i_btn_clr = 1'b1;
    tick();
    i_btn_clr = 1'b0;
    check("clr_beats_step", 32'(o_bcd), 32'h00);
    repeat (4) tick();
    check("step_after_clr", 32'(o_bcd), 32'h99);

    // Button toggle together with 'S' leaves run off
    send_byte("S");
    tick();
    i_btn_run = 1'b1;
    tick();
    i_btn_run = 1'b0;
    check("btn_S_stop", 32'(o_run), 32'h0);
    repeat (2) tick();

    // Reset while waiting in the acknowledge phase
    i_tx_busy = 1'b1;
    send_byte("u");
    repeat (2) tick();
    check("ack_held", 32'(o_tx_start), 32'h0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_rst_bcd",      32'(o_bcd),      32'h00);
    check("mid_rst_tx_data",  32'(o_tx_data),  32'h00);
    check("mid_rst_run",      32'(o_run),      32'h0);
    check("mid_rst_dir",      32'(o_dir),      32'h0);
    check("mid_rst_ovf",      32'(o_fifo_ovf), 32'h0);
    check("mid_rst_tx_start", 32'(o_tx_start), 32'h0);
    repeat (2) tick();
    i_tx_busy = 1'b0;
    reset = 1'b1;
    #1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_tx_start) acks++;
      tick();
    end
    check("no_ack_after_rst", 32'(acks), 32'd0);

    // Randomized traffic checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      i_rx_valid = ($urandom_range(0, 2) == 0);
      i_rx_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
      i_btn_run  = ($urandom_range(0, 30) == 0);
      i_btn_clr  = ($urandom_range(0, 60) == 0);
      i_tx_busy  = ((i % 300) < 25) ? 1'b1 : ($urandom_range(0, 2) == 0);
      tick();
    end
    i_rx_valid = 1'b0;
    i_btn_run  = 1'b0;
    i_btn_clr  = 1'b0;
    i_tx_busy  = 1'b0;
    repeat (20) tick();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_cmd_counter.md
UART_CMD_COUNTER -- requirements
Module: uart_cmd_counter

Interface
REQ-001 SHALL provide parameter DIGITS, default 4, number of BCD digits in the counter (range 1..8).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 8, command FIFO entries (power of 2, range 2..64).
REQ-003 SHALL provide parameter TICK_DIV, default 10_000_000, clk cycles per count step (at least 2).
REQ-004 Port: clk  in  1  single clock; all logic clocked on its rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset.
REQ-006 Port: i_rx_data  in  8  received UART byte.
REQ-007 Port: i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid in that cycle.
REQ-008 Port: i_btn_run  in  1  debounced one-cycle pulse that toggles run.
REQ-009 Port: i_btn_clr  in  1  debounced one-cycle pulse that clears the counter.
REQ-010 Port: i_tx_busy  in  1  UART transmitter busy.
REQ-011 Port: o_tx_data  out  8  acknowledge byte.
REQ-012 Port: o_tx_start  out  1  one-cycle strobe that sends o_tx_data.
REQ-013 Port: o_bcd  out  4*DIGITS  counter value; digit 0 occupies bits [3:0].
REQ-014 Port: o_run  out  1  counter running.
REQ-015 Port: o_dir  out  1  count direction (0 = up, 1 = down).
REQ-016 Port: o_fifo_ovf  out  1  sticky flag: a received byte was dropped.

Function
REQ-017 Push: every i_rx_valid pushes i_rx_data into the FIFO.
REQ-018 Full FIFO: a push while full and not popping SHALL drop the byte and set o_fifo_ovf; a push and pop in the same cycle while full SHALL both succeed.
REQ-019 Controller FSM states SHALL be IDLE, DECODE and ACK.
REQ-020 IDLE: pop one entry when the FIFO is non-empty, then go to DECODE.
REQ-021 DECODE: execute the command (one cycle), latch the ack byte, then go to ACK.
REQ-022 ACK: assert o_tx_start for exactly one cycle in the first cycle with i_tx_busy=0, then return to IDLE.
REQ-023 Latency: i_rx_valid in cycle t into an empty FIFO with the FSM in IDLE gives the command effect on outputs in cycle t+3; o_tx_start rises in cycle t+3 if i_tx_busy=0.
REQ-024 Command 'R'/'r' SHALL toggle run; 'S'/'s' SHALL clear run; 'C'/'c' SHALL clear the counter, the prescaler and o_fifo_ovf; 'U'/'u' SHALL set dir=0; 'D'/'d' SHALL set dir=1.
REQ-025 Ack byte: the received byte for a valid command; 0x3F ('?') for any other byte, with no state change.
REQ-026 Prescaler: counts 0..TICK_DIV-1 while o_run=1 and holds while o_run=0; the terminal count produces a one-cycle step.
REQ-027 Step: BCD up-count wraps from all-9s to 0; BCD down-count wraps from 0 to all-9s; each digit is always 0..9.
REQ-028 Button clear SHALL clear the counter and prescaler only, and SHALL NOT clear o_fifo_ovf.
REQ-029 Priority: clear beats step in the same cycle.
REQ-030 Same-cycle run events: a button run toggle and an 'R' command cancel out; a button toggle and an 'S' command give run=0.
REQ-031 Clear does not alter o_run or o_dir.
REQ-032 A direction change takes effect at the next step; the prescaler is not reset.

Reset
REQ-033 reset low SHALL asynchronously force o_bcd=0, o_run=0, o_dir=0, o_fifo_ovf=0, o_tx_start=0, o_tx_data=0x00, prescaler=0, FIFO empty and FSM=IDLE.
REQ-034 Reset asserted mid-ACK SHALL abandon the ack with no o_tx_start pulse; release is synchronous to clk.

Structure
REQ-035 Package uart_cmd_pkg SHALL hold the command byte constants, the ACK_ERR constant (0x3F) and the FSM state enum.
REQ-036 The FIFO SHALL be a separate sub-module cmd_fifo (parameters WIDTH and DEPTH; push/pop/full/empty; async active-low reset).
REQ-037 The BCD counter and prescaler SHALL remain inside uart_cmd_counter.

Verification (TICK_DIV=4, DIGITS=2, FIFO_DEPTH=4)
REQ-038 Send 'r' with i_tx_busy=0 -> o_run=1 at t+3, one o_tx_start with o_tx_data=0x72, o_bcd=0x01 after 4 cycles.
REQ-039 Run from 0x98 up -> 0x99 then 0x00; send 'd' from 0x00 -> next step gives 0x99.
REQ-040 Hold i_tx_busy=1 and push 6 bytes back-to-back -> o_fifo_ovf=1, only 4 or 5 acks after busy drops; then 'c' -> o_fifo_ovf=0, o_bcd=0.
REQ-041 Send 'x' -> o_tx_data=0x3F, o_run, o_dir and o_bcd unchanged.
REQ-042 Pulse i_btn_run in the same cycle as 'R' executes -> o_run unchanged; i_btn_clr on a step cycle -> o_bcd=0.
REQ-043 Assert reset during ACK with busy=1 -> all outputs at reset values, no o_tx_start after release.
